// File: rtl/rr_burst_scheduler_pkg.sv
// Shared types and defaults for the burst round-robin scheduler.
// State encoding is fixed so the resource-side debug taps stay stable.
package rr_burst_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int BURST_MAX_DEF = 8;
    localparam int TIMEOUT_DEF   = 16;
    localparam int IDX_W         = 3;

endpackage

// File: rtl/rr_burst_scheduler_pick.sv
// Rotating priority encoder: first set req bit searching upward from last+1 (mod N).
// Purely combinational, no backpressure.
module rr_pick
    import rr_burst_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    int idx;

    // Scan from lowest priority to highest so the last hit left standing is the winner.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last) + k) % N;
            if (req[idx]) begin
                win_oh      = '0;
                win_oh[idx] = 1'b1;
                win_idx     = IDX_W'(idx);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_burst_scheduler.sv
// Burst round-robin owner scheduler; grant 1 clock after req, 1-cycle turnaround on release.
// No backpressure: owner releases on done, req drop, beat quota or (ARB_TIMEOUT_EN) idle watchdog.
module rr_burst_scheduler
    import rr_burst_scheduler_pkg::*;
#(
    parameter int N         = 4,
    parameter int BURST_MAX = BURST_MAX_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     done,
    input  logic             beat,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_id,
    output logic             timeout_pulse
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [3:0]         beat_cnt, cnt_d;
    logic [N-1:0]       gnt_d;
    logic [IDX_W-1:0]   id_d;

    logic [N-1:0]       win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;

    logic               own_req, own_done, quota_hit, to_hit, rel;

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .last    (last_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .any     (win_any)
    );

    // gnt is one-hot, so masking picks out the owner's own bits.
    assign own_req   = |(gnt & req);
    assign own_done  = |(gnt & done);
    assign quota_hit = beat && (beat_cnt == 4'(BURST_MAX - 1));
    assign rel       = (state_q == GRANT) && (own_done || !own_req || quota_hit || to_hit);

`ifdef ARB_TIMEOUT_EN
    logic [4:0] idle_cnt, idle_d;

    assign to_hit = (state_q == GRANT) && !beat && (idle_cnt == 5'(TIMEOUT - 1));

    always_comb begin
        idle_d = idle_cnt;
        if (state_q != GRANT || beat || rel) begin
            idle_d = '0;
        end else begin
            idle_d = idle_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            idle_cnt      <= idle_d;
            timeout_pulse <= to_hit;
        end
    end
`else
    assign to_hit        = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = win_any ? GRANT : IDLE;
            GRANT:   state_d = rel ? TURN : GRANT;
            TURN:    state_d = win_any ? GRANT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d  = gnt;
        id_d   = gnt_id;
        last_d = last_q;
        cnt_d  = beat_cnt;
        case (state_q)
            GRANT: begin
                if (beat) begin
                    cnt_d = beat_cnt + 4'd1;
                end
                if (rel) begin
                    gnt_d  = '0;
                    id_d   = '0;
                    last_d = gnt_id;
                    cnt_d  = '0;
                end
            end
            default: begin
                cnt_d = '0;
                if (win_any) begin
                    gnt_d = win_oh;
                    id_d  = win_idx;
                end else begin
                    gnt_d = '0;
                    id_d  = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            last_q    <= IDX_W'(N - 1);
            beat_cnt  <= '0;
        end else begin
            gnt       <= gnt_d;
            gnt_valid <= |gnt_d;
            gnt_id    <= id_d;
            last_q    <= last_d;
            beat_cnt  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_burst_scheduler.sv
// Scoreboard bench: an ownership-level model predicts outputs each cycle, a negedge monitor compares.
module tb_rr_burst_scheduler;

    localparam int N  = 4;
    localparam int BM = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic         beat;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [2:0]   gnt_id;
    logic         timeout_pulse;

    always #5 clk = ~clk;

    rr_burst_scheduler #(.N(N), .BURST_MAX(BM), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .done          (done),
        .beat          (beat),
        .gnt           (gnt),
        .gnt_valid     (gnt_valid),
        .gnt_id        (gnt_id),
        .timeout_pulse (timeout_pulse)
    );

    typedef struct packed {
        logic [N-1:0] g;
        logic         v;
        logic [2:0]   id;
        logic         tp;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;

    // Model: who owns the resource, how many beats/idle cycles it has used, who owned it last.
    int m_owner;
    int m_last;
    int m_beats;
    int m_idle;
    bit m_pulse;

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_beats = 0;
        m_idle  = 0;
        m_pulse = 1'b0;
    endfunction

    function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] d, input logic b);
        bit rel;
        bit tmo;
        bit found;
        rel     = 1'b0;
        tmo     = 1'b0;
        found   = 1'b0;
        m_pulse = 1'b0;
        if (m_owner >= 0) begin
            if (b) begin
                m_beats = m_beats + 1;
                m_idle  = 0;
            end else begin
                m_idle = m_idle + 1;
            end
            if (d[m_owner] || !r[m_owner]) rel = 1'b1;
            if (m_beats == BM) rel = 1'b1;
`ifdef ARB_TIMEOUT_EN
            if (m_idle == TO) begin
                rel = 1'b1;
                tmo = 1'b1;
            end
`endif
            if (rel) begin
                m_last  = m_owner;
                m_owner = -1;
                m_pulse = tmo;
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!found && r[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    found   = 1'b1;
                end
            end
            m_beats = 0;
            m_idle  = 0;
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.g  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e.v  = (m_owner >= 0);
        e.id = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        e.tp = m_pulse;
        return e;
    endfunction

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic b);
        @(posedge clk);
        #1;
        model_step(req, done, beat);
        q.push_back(model_out());
        req  = r;
        done = d;
        beat = b;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e    = q.pop_front();
            compared = compared + 1;
            if ({gnt, gnt_valid, gnt_id, timeout_pulse} !== mon_e) begin
                mismatched = mismatched + 1;
                $display("FAIL outputs @%0t: gnt=%b vld=%b id=%0d tp=%b, expected gnt=%b vld=%b id=%0d tp=%b",
                         $time, gnt, gnt_valid, gnt_id, timeout_pulse, mon_e.g, mon_e.v, mon_e.id, mon_e.tp);
            end
        end
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] d;
        logic         b;
        int           stall;

        rst  = 1'b0;
        req  = '0;
        done = '0;
        beat = 1'b0;
        model_reset();
        @(posedge clk); #1; q.push_back(model_out());
        @(posedge clk); #1; q.push_back(model_out());
        rst = 1'b1;

        // All four requesting, beat every cycle: 8-beat bursts with a turnaround between.
        for (int i = 0; i < 42; i++) step(4'b1111, '0, 1'b1);
        idle_cycles(3);

        // Lone requester 2 releases early on done, then regrants.
        step(4'b0100, '0, 1'b1);
        step(4'b0100, '0, 1'b1);
        step(4'b0100, '0, 1'b1);
        step(4'b0100, 4'b0100, 1'b1);
        for (int i = 0; i < 12; i++) step(4'b0100, '0, 1'b1);
        idle_cycles(3);

        // Owner 0 with a non-owner done pulsed: must be ignored.
        step(4'b0011, '0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0011, 4'b0010, 1'b0);
        step(4'b0011, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0011, '0, 1'b0);
        idle_cycles(3);

        // Owner 2 drops req mid-burst while 3 waits.
        for (int i = 0; i < 3; i++) step(4'b1100, '0, 1'b1);
        for (int i = 0; i < 5; i++) step(4'b1000, '0, 1'b1);
        idle_cycles(3);

        // Asynchronous reset during owner 1's burst; pointer returns to favour requester 0.
        for (int i = 0; i < 4; i++) step(4'b0010, '0, 1'b1);
        @(posedge clk);
        #1;
        model_step(req, done, beat);
        rst = 1'b0;
        #1;
        compared = compared + 1;
        if (gnt !== '0 || gnt_valid !== 1'b0 || gnt_id !== 3'd0 || timeout_pulse !== 1'b0) begin
            mismatched = mismatched + 1;
            $display("FAIL async_reset: gnt=%b vld=%b id=%0d tp=%b, expected all zero",
                     gnt, gnt_valid, gnt_id, timeout_pulse);
        end
        model_reset();
        q.push_back(model_out());
        req  = 4'b0011;
        done = '0;
        beat = 1'b1;
        @(posedge clk); #1; q.push_back(model_out());
        rst = 1'b1;
        for (int i = 0; i < 6; i++) step(4'b0011, '0, 1'b1);
        idle_cycles(3);

        // Stalled owner: watchdog revokes when enabled, otherwise the grant is held.
        for (int i = 0; i < 24; i++) step(4'b0110, '0, 1'b0);
        idle_cycles(3);

        // Randomized traffic with occasional long stalls.
        r     = '0;
        stall = 0;
        for (int i = 0; i < 900; i++) begin
            for (int j = 0; j < N; j++) begin
                if ($urandom_range(7) == 0) r[j] = ~r[j];
            end
            d = ($urandom_range(9) == 0) ? N'(1 << $urandom_range(N - 1)) : '0;
            if (stall == 0 && $urandom_range(59) == 0) stall = $urandom_range(25, 10);
            if (stall > 0) begin
                b     = 1'b0;
                stall = stall - 1;
            end else begin
                b = ($urandom_range(3) != 0);
            end
            step(r, d, b);
        end
        idle_cycles(2);

        repeat (2) @(negedge clk);
        #1;
        compared = compared + 1;
        if (q.size() != 0) begin
            mismatched = mismatched + 1;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
